vga_draw_scheduler: RTL and testbench

Sequences all writes into the VGA adapter plot port. It shares that port between two requesters:
- full-frame background redraws read from the image ROM bank (memory_controller);
- solid-colour rectangle fills used for the beat/needle overlay.

It owns the pixel counters, generates ROM addresses and ROM chip-select, and delays coordinates so that oX/oY/oPlot line up with the ROM's registered read data.

---
 rtl/vga_draw_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_vga_draw_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_scheduler.sv
// Plot-port sequencer: background ROM redraws and solid overlay fills share one VGA plot port.
// Build option VGA_COLOUR_KEY_EN: background pixels equal to KEY_COLOUR are not plotted.
module vga_draw_scheduler #(
  parameter int         WIDTH       = 160,
  parameter int         HEIGHT      = 120,
  parameter int         ROM_LATENCY = 1,
  parameter logic [2:0] KEY_COLOUR  = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bg_req,
  input  logic [7:0]  bg_index,
  output logic        bg_ack,
  input  logic        ov_req,
  input  logic [7:0]  ov_x0,
  input  logic [6:0]  ov_y0,
  input  logic [7:0]  ov_w,
  input  logic [6:0]  ov_h,
  input  logic [2:0]  ov_colour,
  output logic        ov_ack,
  output logic [14:0] rom_address,
  output logic [7:0]  rom_select,
  input  logic [2:0]  rom_q,
  output logic [7:0]  oX,
  output logic [6:0]  oY,
  output logic [2:0]  oColour,
  output logic        oPlot,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BG    = 2'd1;
  localparam logic [1:0] S_OV    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [8:0]  X_MAX      = 9'(WIDTH - 1);
  localparam logic [7:0]  Y_MAX      = 8'(HEIGHT - 1);
  localparam logic [8:0]  X_LIMIT    = 9'(WIDTH);
  localparam logic [7:0]  Y_LIMIT    = 8'(HEIGHT);
  localparam logic [1:0]  DRAIN_LAST = 2'(ROM_LATENCY - 1);
  localparam logic [15:0] WIDTH_W    = 16'(WIDTH);

  logic [1:0] state_reg;
  logic [8:0] x_cnt_reg, x_start_reg, x_last_reg;
  logic [7:0] y_cnt_reg, y_last_reg;
  logic [2:0] colour_reg;
  logic [1:0] drain_reg;

  logic [8:0]  ov_x_last;
  logic [7:0]  ov_y_last;
  logic        row_end, in_range, issue_valid, is_bg;
  logic [15:0] y_ext, row_base, addr_full;

  // Wider internal counters let overlays run off-screen without wrapping back on.
  assign ov_x_last   = {1'b0, ov_x0} + {1'b0, ov_w} - 9'd1;
  assign ov_y_last   = {1'b0, ov_y0} + {1'b0, ov_h} - 8'd1;
  assign row_end     = (x_cnt_reg == x_last_reg);
  assign in_range    = (x_cnt_reg < X_LIMIT) && (y_cnt_reg < Y_LIMIT);
  assign is_bg       = (state_reg == S_BG);
  assign issue_valid = is_bg || ((state_reg == S_OV) && in_range);
  assign busy        = (state_reg != S_IDLE);

  assign y_ext = {8'd0, y_cnt_reg};
  if (WIDTH == 160) begin : g_row_shift
    assign row_base = (y_ext << 7) + (y_ext << 5);
  end else begin : g_row_mul
    assign row_base = y_ext * WIDTH_W;
  end
  assign addr_full   = row_base + {7'd0, x_cnt_reg};
  assign rom_address = addr_full[14:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      x_cnt_reg   <= '0;
      y_cnt_reg   <= '0;
      x_start_reg <= '0;
      x_last_reg  <= '0;
      y_last_reg  <= '0;
      colour_reg  <= '0;
      drain_reg   <= '0;
      bg_ack      <= 1'b0;
      ov_ack      <= 1'b0;
      rom_select  <= '0;
    end else begin
      bg_ack <= 1'b0;
      ov_ack <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // Background wins: a full redraw would erase any overlay anyway.
          if (bg_req) begin
            bg_ack      <= 1'b1;
            rom_select  <= bg_index;
            x_start_reg <= '0;
            x_last_reg  <= X_MAX;
            y_last_reg  <= Y_MAX;
            x_cnt_reg   <= '0;
            y_cnt_reg   <= '0;
            state_reg   <= S_BG;
          end else if (ov_req) begin
            ov_ack      <= 1'b1;
            colour_reg  <= ov_colour;
            x_start_reg <= {1'b0, ov_x0};
            x_last_reg  <= ov_x_last;
            y_last_reg  <= ov_y_last;
            x_cnt_reg   <= {1'b0, ov_x0};
            y_cnt_reg   <= {1'b0, ov_y0};
            drain_reg   <= '0;
            state_reg   <= ((ov_w == 8'd0) || (ov_h == 7'd0)) ? S_DRAIN : S_OV;
          end
        end
        S_BG, S_OV: begin
          if (row_end) begin
            x_cnt_reg <= x_start_reg;
            if (y_cnt_reg == y_last_reg) begin
              state_reg <= S_DRAIN;
              drain_reg <= '0;
            end else begin
              y_cnt_reg <= y_cnt_reg + 8'd1;
            end
          end else begin
            x_cnt_reg <= x_cnt_reg + 9'd1;
          end
        end
        S_DRAIN: begin
          if (drain_reg == DRAIN_LAST) state_reg <= S_IDLE;
          else drain_reg <= drain_reg + 2'd1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Coordinate pipeline whose last stage lines up with the ROM's registered data.
  for (genvar gi = 0; gi < ROM_LATENCY; gi++) begin : g_pipe
    logic [7:0] x_in, x_reg;
    logic [6:0] y_in, y_reg;
    logic [2:0] c_in, c_reg;
    logic       v_in, v_reg, bg_in, bg_reg;
    if (gi == 0) begin : g_head
      assign x_in  = x_cnt_reg[7:0];
      assign y_in  = y_cnt_reg[6:0];
      assign c_in  = colour_reg;
      assign v_in  = issue_valid;
      assign bg_in = is_bg;
    end else begin : g_tail
      assign x_in  = g_pipe[gi-1].x_reg;
      assign y_in  = g_pipe[gi-1].y_reg;
      assign c_in  = g_pipe[gi-1].c_reg;
      assign v_in  = g_pipe[gi-1].v_reg;
      assign bg_in = g_pipe[gi-1].bg_reg;
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        x_reg  <= '0;
        y_reg  <= '0;
        c_reg  <= '0;
        v_reg  <= 1'b0;
        bg_reg <= 1'b0;
      end else begin
        x_reg  <= x_in;
        y_reg  <= y_in;
        c_reg  <= c_in;
        v_reg  <= v_in;
        bg_reg <= bg_in;
      end
    end
  end

  logic plot_next;
`ifdef VGA_COLOUR_KEY_EN
  assign plot_next = g_pipe[ROM_LATENCY-1].v_reg &&
                     !(g_pipe[ROM_LATENCY-1].bg_reg && (rom_q == KEY_COLOUR));
`else
  assign plot_next = g_pipe[ROM_LATENCY-1].v_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
    end else begin
      oX      <= g_pipe[ROM_LATENCY-1].x_reg;
      oY      <= g_pipe[ROM_LATENCY-1].y_reg;
      oColour <= g_pipe[ROM_LATENCY-1].bg_reg ? rom_q : g_pipe[ROM_LATENCY-1].c_reg;
      oPlot   <= plot_next;
    end
  end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: frame redraws, overlay table, arbitration, mid-job reset.
module tb_vga_draw_scheduler;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] c;
    int         exp_plots;
    int         exp_busy;
  } ov_vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bg_req = 1'b0;
  logic [7:0]  bg_index = '0;
  logic        bg_ack;
  logic        ov_req = 1'b0;
  logic [7:0]  ov_x0 = '0;
  logic [6:0]  ov_y0 = '0;
  logic [7:0]  ov_w = '0;
  logic [6:0]  ov_h = '0;
  logic [2:0]  ov_colour = '0;
  logic        ov_ack;
  logic [14:0] rom_address;
  logic [7:0]  rom_select;
  logic [2:0]  rom_q = '0;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot;
  logic        busy;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   plot_count = 0;
  int   bg_ack_count = 0;
  pix_t exp_q[$];

  vga_draw_scheduler dut (
    .clk(clk), .reset(reset),
    .bg_req(bg_req), .bg_index(bg_index), .bg_ack(bg_ack),
    .ov_req(ov_req), .ov_x0(ov_x0), .ov_y0(ov_y0), .ov_w(ov_w), .ov_h(ov_h),
    .ov_colour(ov_colour), .ov_ack(ov_ack),
    .rom_address(rom_address), .rom_select(rom_select), .rom_q(rom_q),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_data(input logic [14:0] a, input logic [7:0] s);
    logic [14:0] t;
    t = a ^ (a >> 5) ^ {7'd0, s};
    return t[2:0] ^ t[5:3];
  endfunction

  // One-cycle registered ROM, content depends on the selected image.
  always @(posedge clk) rom_q <= rom_data(rom_address, rom_select);

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    if (bg_ack) bg_ack_count++;
    if (oPlot) begin
      plot_count++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_plot", {oX, oY}, 0);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        chk({oX, oY, oColour} == {e.x, e.y, e.c}, "plot_xyc", {oX, oY, oColour}, {e.x, e.y, e.c});
      end
    end
  end

  task automatic push_frame(input logic [7:0] sel);
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        pix_t p;
        p.x = 8'(xx);
        p.y = 7'(yy);
        p.c = rom_data(15'(yy * 160 + xx), sel);
`ifdef VGA_COLOUR_KEY_EN
        if (p.c == 3'b000) continue;
`endif
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic push_ov(input ov_vec_t v);
    for (int yy = int'(v.y0); yy < int'(v.y0) + int'(v.h); yy++) begin
      for (int xx = int'(v.x0); xx < int'(v.x0) + int'(v.w); xx++) begin
        pix_t p;
        if (xx >= 160 || yy >= 120) continue;
        p.x = 8'(xx);
        p.y = 7'(yy);
        p.c = v.c;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic wait_ack(input bit is_bg, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (is_bg ? bg_ack : ov_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_ov(input ov_vec_t v, input int idx);
    bit ok;
    int n, base;
    base = plot_count;
    push_ov(v);
    @(negedge clk);
    ov_x0 = v.x0; ov_y0 = v.y0; ov_w = v.w; ov_h = v.h; ov_colour = v.c;
    ov_req = 1'b1;
    wait_ack(1'b0, 10, ok);
    chk(ok, "ov_ack_seen", ok, 1);
    chk(busy == 1'b1, "ov_busy_at_ack", busy, 1);
    ov_req = 1'b0;
    @(negedge clk);
    chk(ov_ack == 1'b0, "ov_ack_width", ov_ack, 0);
    wait_idle(600, n);
    chk(n + 1 == v.exp_busy, "ov_busy_cycles", n + 1, v.exp_busy);
    repeat (3) @(negedge clk);
    chk(plot_count - base == v.exp_plots, "ov_plot_count", plot_count - base, v.exp_plots);
    chk(exp_q.size() == 0, "ov_queue_empty", exp_q.size(), 0);
    $display("overlay job %0d: x0=%0d y0=%0d w=%0d h=%0d plots=%0d busy=%0d",
             idx, v.x0, v.y0, v.w, v.h, plot_count - base, n + 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    ov_vec_t tbl[6];
    ov_vec_t both_ov;
    bit ok;
    int n, base, acks, exp_cnt;

    tbl[0] = '{x0: 8'd10,  y0: 7'd20,  w: 8'd4, h: 7'd2, c: 3'd5, exp_plots: 8, exp_busy: 9};
    tbl[1] = '{x0: 8'd158, y0: 7'd119, w: 8'd4, h: 7'd3, c: 3'd6, exp_plots: 2, exp_busy: 13};
    tbl[2] = '{x0: 8'd0,   y0: 7'd0,   w: 8'd0, h: 7'd5, c: 3'd1, exp_plots: 0, exp_busy: 1};
    tbl[3] = '{x0: 8'd50,  y0: 7'd60,  w: 8'd1, h: 7'd1, c: 3'd7, exp_plots: 1, exp_busy: 2};
    tbl[4] = '{x0: 8'd255, y0: 7'd127, w: 8'd3, h: 7'd2, c: 3'd2, exp_plots: 0, exp_busy: 7};
    tbl[5] = '{x0: 8'd100, y0: 7'd5,   w: 8'd3, h: 7'd0, c: 3'd3, exp_plots: 0, exp_busy: 1};

    #1;
    chk({bg_ack, ov_ack, rom_address, rom_select, oX, oY, oColour, oPlot, busy} == '0,
        "reset_outputs", {rom_address, oX, oY}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk(busy == 1'b0, "idle_after_reset", busy, 0);

    // Full background frame.
    base = plot_count;
    acks = bg_ack_count;
    push_frame(8'd3);
    exp_cnt = exp_q.size();
    bg_index = 8'd3;
    bg_req = 1'b1;
    wait_ack(1'b1, 10, ok);
    chk(ok, "bg_ack_seen", ok, 1);
    bg_req = 1'b0;
    chk(rom_select == 8'd3, "bg_rom_select", rom_select, 3);
    @(negedge clk);
    chk(oPlot == 1'b0, "bg_plot_not_early", oPlot, 0);
    @(negedge clk);
    chk({oPlot, oX, oY} == {1'b1, 8'd0, 7'd0}, "bg_first_plot_ack_plus2", {oPlot, oX, oY}, {1'b1, 8'd0, 7'd0});
    wait_idle(19400, n);
    chk(busy == 1'b0, "bg_done", busy, 0);
    chk({oPlot, oX, oY} == {1'b1, 8'd159, 7'd119}, "bg_last_plot_busy_low", {oPlot, oX, oY}, {1'b1, 8'd159, 7'd119});
    repeat (3) @(negedge clk);
    chk(plot_count - base == exp_cnt, "bg_plot_count", plot_count - base, exp_cnt);
    chk(bg_ack_count - acks == 1, "bg_ack_once", bg_ack_count - acks, 1);
    chk(rom_select == 8'd3, "bg_rom_select_held", rom_select, 3);
    chk(exp_q.size() == 0, "bg_queue_empty", exp_q.size(), 0);
    $display("background job: index=3 plots=%0d busy_cycles=%0d", plot_count - base, n + 2);

    for (int i = 0; i < 6; i++) run_ov(tbl[i], i);

    // Simultaneous requests: background first, overlay right after the frame.
    both_ov = tbl[0];
    push_frame(8'd2);
    push_ov(both_ov);
    @(negedge clk);
    ov_x0 = both_ov.x0; ov_y0 = both_ov.y0; ov_w = both_ov.w; ov_h = both_ov.h; ov_colour = both_ov.c;
    bg_index = 8'd2;
    bg_req = 1'b1;
    ov_req = 1'b1;
    wait_ack(1'b1, 10, ok);
    chk(ok, "both_bg_ack_seen", ok, 1);
    chk(ov_ack == 1'b0, "both_ov_not_first", ov_ack, 0);
    bg_req = 1'b0;
    @(negedge clk);
    wait_idle(19400, n);
    chk(busy == 1'b0, "both_frame_done", busy, 0);
    chk(ov_ack == 1'b0, "both_ov_ack_not_in_idle", ov_ack, 0);
    @(negedge clk);
    chk(ov_ack == 1'b1, "both_ov_ack_after_drain", ov_ack, 1);
    ov_req = 1'b0;
    @(negedge clk);
    wait_idle(100, n);
    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "both_queue_empty", exp_q.size(), 0);
    chk(rom_select == 8'd2, "both_rom_select", rom_select, 2);
    $display("arbitration job: bg index=2 then overlay, queue left=%0d", exp_q.size());

    // Reset mid-frame with the request still held.
    base = plot_count;
    push_frame(8'd9);
    bg_index = 8'd9;
    bg_req = 1'b1;
    wait_ack(1'b1, 10, ok);
    chk(ok, "rst_bg_ack_seen", ok, 1);
    n = 0;
    while (plot_count - base < 5000 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk(plot_count - base == 5000, "rst_reached_5000", plot_count - base, 5000);
    #2 reset = 1'b0;
    #1;
    chk({oPlot, oX, oY, oColour, busy, bg_ack} == '0, "rst_outputs_zero", {oPlot, oX, oY, oColour, busy}, 0);
    chk(rom_select == 8'd0, "rst_rom_select_zero", rom_select, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    base = plot_count;
    push_frame(8'd9);
    reset = 1'b1;
    wait_ack(1'b1, 10, ok);
    chk(ok, "rst_reack_seen", ok, 1);
    chk(rom_select == 8'd9, "rst_rom_select_relatched", rom_select, 9);
    @(negedge clk);
    @(negedge clk);
    chk({oPlot, oX, oY} == {1'b1, 8'd0, 7'd0}, "rst_restart_origin", {oPlot, oX, oY}, {1'b1, 8'd0, 7'd0});
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    bg_req = 1'b0;
    #1;
    chk({oPlot, busy} == 2'b00, "rst_second_abort", {oPlot, busy}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk(busy == 1'b0, "rst_idle_after_release", busy, 0);
    $display("reset job: restart plots=%0d before abort", plot_count - base);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
